// File: rtl/alu_op_dispatcher.sv
// ALU unit initiator: issues one command at a time, waits for the unit flag; optional WAIT abort under DISPATCH_TIMEOUT_EN.
// Result valid two cycles after accept for a unit flagging one cycle after enable; held while res_ready is low, no new command meanwhile.
module alu_op_dispatcher #(
    parameter int WIDTH       = 16,
    parameter int TIMEOUT_CYC = 15,
    parameter int CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WIDTH-1:0]     cmd_A,
    input  logic [WIDTH-1:0]     cmd_B,
    input  logic [3:0]           cmd_FUN,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic [1:0]           ALU_FUN,
    output logic [3:0]           unit_en,
    input  logic [4*WIDTH-1:0]   unit_out,
    input  logic [3:0]           unit_flag,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WIDTH-1:0]     res_data,
    output logic [1:0]           res_unit,
    output logic                 res_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             capture;
    logic             abort;
    logic             flag_sel;
    logic             expire;
    logic [WIDTH-1:0] sel_out;

    generate
        if (TIMEOUT_CYC >= (1 << CNT_W)) begin : g_cfg_check
            $error("TIMEOUT_CYC must be below 2**CNT_W");
        end
    endgenerate

    // res_unit doubles as the selected-unit register for the whole transaction
    assign flag_sel = unit_flag[res_unit];
    assign sel_out  = unit_out[res_unit*WIDTH +: WIDTH];

`ifdef DISPATCH_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;

    assign expire = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == ISSUE) begin
            cnt <= '0;
        end else if (state == WAIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_err <= 1'b0;
        end else if (capture) begin
            res_err <= 1'b0;
        end else if (abort) begin
            res_err <= 1'b1;
        end
    end
`else
    assign expire  = 1'b0;
    assign res_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                // a flag in the expiry cycle still counts as a normal result
                if (flag_sel) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end else if (expire) begin
                    abort     = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            A        <= '0;
            B        <= '0;
            ALU_FUN  <= 2'b00;
            res_unit <= 2'b00;
            res_data <= '0;
        end else begin
            if (accept) begin
                A        <= cmd_A;
                B        <= cmd_B;
                ALU_FUN  <= cmd_FUN[1:0];
                res_unit <= cmd_FUN[3:2];
            end
            if (capture) begin
                res_data <= sel_out;
            end else if (abort) begin
                res_data <= '0;
            end
        end
    end

    // cmd_ready is gated by rst so every output reads 0 while reset is held
    assign cmd_ready = rst && (state == IDLE);
    assign unit_en   = (state == ISSUE) ? (4'b0001 << res_unit) : 4'b0000;
    assign res_valid = (state == HOLD);

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Directed bench for alu_op_dispatcher: inputs driven and outputs sampled on the falling edge.
module tb_alu_op_dispatcher;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_A;
    logic [15:0] cmd_B;
    logic [3:0]  cmd_FUN;
    logic [15:0] A;
    logic [15:0] B;
    logic [1:0]  ALU_FUN;
    logic [3:0]  unit_en;
    logic [63:0] unit_out;
    logic [3:0]  unit_flag;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [1:0]  res_unit;
    logic        res_err;

    int vectors;
    int miscompares;
    logic seen_valid;

    alu_op_dispatcher #(.WIDTH(16), .TIMEOUT_CYC(15), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_FUN(cmd_FUN),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .unit_en(unit_en),
        .unit_out(unit_out), .unit_flag(unit_flag),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_unit(res_unit), .res_err(res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        cmd_valid   = 1'b0;
        cmd_A       = 16'h0000;
        cmd_B       = 16'h0000;
        cmd_FUN     = 4'h0;
        unit_out    = 64'h0;
        unit_flag   = 4'h0;
        res_ready   = 1'b1;   // high before res_valid must have no effect

        #2;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_unit_en", unit_en, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_A", A, 0);
        step();
        rst = 1'b1;
        step();
        chk("idle_cmd_ready", cmd_ready, 1);

        // 1. CMP
        cmd_valid = 1'b1; cmd_FUN = 4'b1010; cmd_A = 16'd5; cmd_B = 16'hFFFD;
        step();
        cmd_valid = 1'b0;
        chk("cmp_unit_en", unit_en, 4'b0100);
        chk("cmp_cmd_ready", cmd_ready, 0);
        chk("cmp_A", A, 16'h0005);
        chk("cmp_B", B, 16'hFFFD);
        chk("cmp_fun", ALU_FUN, 2'b10);
        step();
        chk("cmp_en_pulse", unit_en, 0);
        chk("cmp_wait_valid", res_valid, 0);
        unit_flag = 4'b0100; unit_out[32 +: 16] = 16'h0002;
        step();
        unit_flag = 4'b0000;
        chk("cmp_res_valid", res_valid, 1);
        chk("cmp_res_data", res_data, 16'h0002);
        chk("cmp_res_unit", res_unit, 2);
        chk("cmp_res_err", res_err, 0);
        step();
        chk("cmp_valid_fall", res_valid, 0);
        chk("cmp_ready_back", cmd_ready, 1);

        // 2. Arith
        cmd_valid = 1'b1; cmd_FUN = 4'b0000; cmd_A = 16'hFFF9; cmd_B = 16'd2;
        step();
        cmd_valid = 1'b0;
        chk("ari_unit_en", unit_en, 4'b0001);
        step();
        unit_flag = 4'b0001; unit_out[0 +: 16] = 16'hFFFB;
        step();
        unit_flag = 4'b0000;
        chk("ari_res_valid", res_valid, 1);
        chk("ari_res_data", res_data, 16'hFFFB);
        chk("ari_res_unit", res_unit, 0);
        step();

        // 3. Backpressure, with a second command held on cmd_valid
        res_ready = 1'b0;
        cmd_valid = 1'b1; cmd_FUN = 4'b0111; cmd_A = 16'h1234; cmd_B = 16'h00FF;
        step();
        cmd_FUN = 4'b1101; cmd_A = 16'h8000; cmd_B = 16'h0001;
        chk("bp_unit_en", unit_en, 4'b0010);
        step();
        unit_flag = 4'b0010; unit_out[16 +: 16] = 16'h0034;
        step();
        unit_flag = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", res_valid, 1);
            chk("bp_data_held", res_data, 16'h0034);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_A_held", A, 16'h1234);
            chk("bp_fun_held", ALU_FUN, 2'b11);
            step();
        end
        res_ready = 1'b1;
        step();
        chk("bp_valid_fall", res_valid, 0);
        chk("bp_ready_back", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("bp2_unit_en", unit_en, 4'b1000);
        chk("bp2_A", A, 16'h8000);
        chk("bp2_fun", ALU_FUN, 2'b01);

        // 4. Spurious flag from an unselected unit
        step();
        unit_flag = 4'b0010; unit_out[16 +: 16] = 16'hDEAD; unit_out[48 +: 16] = 16'hBEEF;
        step();
        chk("spur_ignored0", res_valid, 0);
        step();
        chk("spur_ignored1", res_valid, 0);
        unit_flag = 4'b1010;
        step();
        unit_flag = 4'b0000;
        chk("spur_res_valid", res_valid, 1);
        chk("spur_res_data", res_data, 16'hBEEF);
        chk("spur_res_unit", res_unit, 3);
        step();
        chk("spur_valid_fall", res_valid, 0);

        // 5. No flag at all
        cmd_valid = 1'b1; cmd_FUN = 4'b0100; cmd_A = 16'h0F0F; cmd_B = 16'h00FF;
        step();
        cmd_valid = 1'b0;
        step();
`ifdef DISPATCH_TIMEOUT_EN
        seen_valid = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            seen_valid = seen_valid | res_valid;
        end
        chk("to_not_early", seen_valid, 0);
        step();
        chk("to_res_valid", res_valid, 1);
        chk("to_res_err", res_err, 1);
        chk("to_res_data", res_data, 16'h0000);
        chk("to_res_unit", res_unit, 1);
        step();
        cmd_valid = 1'b1; cmd_FUN = 4'b1100;
        step();
        cmd_valid = 1'b0;
        step();
`else
        seen_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            seen_valid = seen_valid | res_valid | cmd_ready;
        end
        chk("nto_still_wait", seen_valid, 0);
`endif

        // 6. Reset pulse in WAIT
        #1;
        rst = 1'b0;
        #1;
        chk("mrst_cmd_ready", cmd_ready, 0);
        chk("mrst_A", A, 0);
        chk("mrst_B", B, 0);
        chk("mrst_fun", ALU_FUN, 0);
        chk("mrst_unit_en", unit_en, 0);
        chk("mrst_res_valid", res_valid, 0);
        chk("mrst_res_data", res_data, 0);
        chk("mrst_res_unit", res_unit, 0);
        chk("mrst_res_err", res_err, 0);
        step();
        rst = 1'b1;
        #1;
        chk("mrst_ready_after", cmd_ready, 1);
        unit_flag = 4'b1111; unit_out = 64'h1111_2222_3333_4444;
        seen_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen_valid = seen_valid | res_valid;
        end
        unit_flag = 4'b0000;
        chk("mrst_late_flag", seen_valid, 0);
        chk("mrst_data_clear", res_data, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
